// File: rtl/fib_checker_if.sv
// Sample/result bundle for fib_checker: the generator word and its qualifier
// flow in, the checker status flows out.
interface fib_checker_if #(
  parameter int W     = 96,
  parameter int CNT_W = 16
);
  logic             en;
  logic [W-1:0]     y;
  logic             locked;
  logic             err;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] sample_cnt;
  logic [CNT_W-1:0] first_err_idx;
  logic             ovf;

  modport master (
    output en, y,
    input  locked, err, err_cnt, sample_cnt, first_err_idx, ovf
  );

  modport slave (
    input  en, y,
    output locked, err, err_cnt, sample_cnt, first_err_idx, ovf
  );
endinterface

// File: rtl/fib_checker.sv
// fib_checker: checks that a sampled word stream obeys y[n] = y[n-1] + y[n-2].
// Optional build macro FIB_CHECKER_OVF_EN: a carry out of the W-bit sum raises
// ovf and parks the checker in HALT instead of wrapping the sum.
//
// state | meaning
// IDLE  | waiting for the first seed sample
// SEED  | first seed held in a, waiting for the second seed
// CHECK | each sample compared against a+b, then a<=b, b<=y
// HALT  | arithmetic overflow seen; frozen until reset
module fib_checker #(
  parameter int W     = 96,
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  fib_checker_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SEED, CHECK, HALT} state_t;

  state_t           state_q, state_nxt;
  logic [W-1:0]     a_q, a_nxt;
  logic [W-1:0]     b_q, b_nxt;
  logic             locked_q, locked_nxt;
  logic             err_q, err_nxt;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_nxt;
  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_nxt;
  logic [CNT_W-1:0] first_err_idx_q, first_err_idx_nxt;
  logic             do_check;

`ifdef FIB_CHECKER_OVF_EN
  logic             ovf_q, ovf_nxt;
  logic [W:0]       sum;
  assign sum = {1'b0, a_q} + {1'b0, b_q};
`else
  logic [W-1:0]     sum;
  assign sum = a_q + b_q;
`endif

  // Counters stick at all-ones rather than wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // Next-state and next-register values; only a sampling edge changes anything.
  always_comb begin
    state_nxt         = state_q;
    a_nxt             = a_q;
    b_nxt             = b_q;
    locked_nxt        = locked_q;
    err_nxt           = err_q;
    err_cnt_nxt       = err_cnt_q;
    sample_cnt_nxt    = sample_cnt_q;
    first_err_idx_nxt = first_err_idx_q;
    do_check          = 1'b0;
`ifdef FIB_CHECKER_OVF_EN
    ovf_nxt           = ovf_q;
`endif
    if (bus.en) begin
      case (state_q)
        IDLE: begin
          a_nxt          = bus.y;
          sample_cnt_nxt = CNT_W'(1);
          state_nxt      = SEED;
        end
        SEED: begin
          b_nxt          = bus.y;
          locked_nxt     = 1'b1;
          sample_cnt_nxt = CNT_W'(2);
          state_nxt      = CHECK;
        end
        CHECK: begin
          do_check = 1'b1;
`ifdef FIB_CHECKER_OVF_EN
          // An overflowing sum is not a meaningful expectation: freeze instead.
          if (sum[W]) begin
            do_check  = 1'b0;
            ovf_nxt   = 1'b1;
            state_nxt = HALT;
          end
`endif
          if (do_check) begin
            a_nxt          = b_q;
            b_nxt          = bus.y;
            sample_cnt_nxt = sat_inc(sample_cnt_q);
            if (sum[W-1:0] != bus.y) begin
              err_nxt     = 1'b1;
              err_cnt_nxt = sat_inc(err_cnt_q);
              if (!err_q) first_err_idx_nxt = sample_cnt_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= IDLE;
      a_q             <= '0;
      b_q             <= '0;
      locked_q        <= 1'b0;
      err_q           <= 1'b0;
      err_cnt_q       <= '0;
      sample_cnt_q    <= '0;
      first_err_idx_q <= '0;
`ifdef FIB_CHECKER_OVF_EN
      ovf_q           <= 1'b0;
`endif
    end else begin
      state_q         <= state_nxt;
      a_q             <= a_nxt;
      b_q             <= b_nxt;
      locked_q        <= locked_nxt;
      err_q           <= err_nxt;
      err_cnt_q       <= err_cnt_nxt;
      sample_cnt_q    <= sample_cnt_nxt;
      first_err_idx_q <= first_err_idx_nxt;
`ifdef FIB_CHECKER_OVF_EN
      ovf_q           <= ovf_nxt;
`endif
    end
  end

  assign bus.locked        = locked_q;
  assign bus.err           = err_q;
  assign bus.err_cnt       = err_cnt_q;
  assign bus.sample_cnt    = sample_cnt_q;
  assign bus.first_err_idx = first_err_idx_q;
`ifdef FIB_CHECKER_OVF_EN
  assign bus.ovf           = ovf_q;
`else
  assign bus.ovf           = 1'b0;
`endif

endmodule

// File: tb/tb_fib_checker.sv
// Scoreboard bench for fib_checker: three instances (W=96; W=8; W=8 with 2-bit
// counters). The driver pushes hand-computed expected status per cycle; a
// monitor pops and compares one entry after each rising edge.
module tb_fib_checker;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fib_checker_if #(.W(96), .CNT_W(16)) if0 ();
  fib_checker_if #(.W(8),  .CNT_W(16)) if1 ();
  fib_checker_if #(.W(8),  .CNT_W(2))  if2 ();

  fib_checker #(.W(96), .CNT_W(16)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  fib_checker #(.W(8),  .CNT_W(16)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  fib_checker #(.W(8),  .CNT_W(2))  dut2 (.clk(clk), .rst(rst), .bus(if2));

  typedef struct {
    int          d;
    logic        locked;
    logic        err;
    logic [15:0] ecnt;
    logic [15:0] scnt;
    logic [15:0] fidx;
    logic        ovf;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cur    = 0;

  task automatic chk(input string name, input int d, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, d, act, exp, $time);
    end
  endtask

  // Monitor: one scoreboard entry per rising edge, sampled 1 ns after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        case (e.d)
          0: begin
            chk("locked", 0, 16'(if0.locked), 16'(e.locked));
            chk("err",    0, 16'(if0.err),    16'(e.err));
            chk("err_cnt",0, if0.err_cnt,     e.ecnt);
            chk("sample_cnt",0, if0.sample_cnt, e.scnt);
            chk("first_err_idx",0, if0.first_err_idx, e.fidx);
            chk("ovf",    0, 16'(if0.ovf),    16'(e.ovf));
          end
          1: begin
            chk("locked", 1, 16'(if1.locked), 16'(e.locked));
            chk("err",    1, 16'(if1.err),    16'(e.err));
            chk("err_cnt",1, if1.err_cnt,     e.ecnt);
            chk("sample_cnt",1, if1.sample_cnt, e.scnt);
            chk("first_err_idx",1, if1.first_err_idx, e.fidx);
            chk("ovf",    1, 16'(if1.ovf),    16'(e.ovf));
          end
          default: begin
            chk("locked", 2, 16'(if2.locked), 16'(e.locked));
            chk("err",    2, 16'(if2.err),    16'(e.err));
            chk("err_cnt",2, 16'(if2.err_cnt), e.ecnt);
            chk("sample_cnt",2, 16'(if2.sample_cnt), e.scnt);
            chk("first_err_idx",2, 16'(if2.first_err_idx), e.fidx);
            chk("ovf",    2, 16'(if2.ovf),    16'(e.ovf));
          end
        endcase
      end
    end
  end

  task automatic push(input logic l, input logic er, input logic [15:0] ec,
                      input logic [15:0] sc, input logic [15:0] fi, input logic ov);
    exp_t e;
    e.d = cur; e.locked = l; e.err = er; e.ecnt = ec;
    e.scnt = sc; e.fidx = fi; e.ovf = ov;
    sbq.push_back(e);
  endtask

  // Drive one cycle on the current instance and record the status expected after the edge.
  task automatic step(input logic e, input logic [95:0] yv, input logic l, input logic er,
                      input logic [15:0] ec, input logic [15:0] sc, input logic [15:0] fi,
                      input logic ov);
    @(negedge clk);
    if0.en = (cur == 0) && e;
    if1.en = (cur == 1) && e;
    if2.en = (cur == 2) && e;
    if0.y  = yv;
    if1.y  = yv[7:0];
    if2.y  = yv[7:0];
    push(l, er, ec, sc, fi, ov);
  endtask

  task automatic do_reset();
    @(negedge clk);
    if0.en = 1'b0; if1.en = 1'b0; if2.en = 1'b0;
    rst = 1'b0;
    push(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int budget;
    if0.en = 1'b0; if1.en = 1'b0; if2.en = 1'b0;
    if0.y = '0; if1.y = '0; if2.y = '0;
    repeat (2) @(posedge clk);

    // Clean Fibonacci run on the wide instance.
    cur = 0;
    do_reset();
    step(1, 0, 0,0,0,1,0,0);
    step(1, 1, 1,0,0,2,0,0);
    step(1, 1, 1,0,0,3,0,0);
    step(1, 2, 1,0,0,4,0,0);
    step(1, 3, 1,0,0,5,0,0);
    step(1, 5, 1,0,0,6,0,0);
    step(1, 8, 1,0,0,7,0,0);

    // Mismatch at index 3, later samples follow the received values.
    do_reset();
    step(1, 0, 0,0,0,1,0,0);
    step(1, 1, 1,0,0,2,0,0);
    step(1, 1, 1,0,0,3,0,0);
    step(1, 3, 1,1,1,4,3,0);
    step(1, 4, 1,1,1,5,3,0);
    step(1, 7, 1,1,1,6,3,0);

    // Enable gaps with junk on y are transparent.
    do_reset();
    step(1, 0,          0,0,0,1,0,0);
    step(0, 96'hDEAD,   0,0,0,1,0,0);
    step(0, 96'hBEEF,   0,0,0,1,0,0);
    step(1, 1,          1,0,0,2,0,0);
    step(0, 96'h77,     1,0,0,2,0,0);
    step(1, 1,          1,0,0,3,0,0);
    step(1, 2,          1,0,0,4,0,0);

    // Reset mid-sequence discards seeds; re-seed with 5,8.
    do_reset();
    step(1, 0, 0,0,0,1,0,0);
    step(1, 1, 1,0,0,2,0,0);
    step(1, 1, 1,0,0,3,0,0);
    step(1, 2, 1,0,0,4,0,0);
    step(1, 9, 1,1,1,5,4,0);
    do_reset();
    step(1, 5,  0,0,0,1,0,0);
    step(1, 8,  1,0,0,2,0,0);
    step(1, 13, 1,0,0,3,0,0);

    // W=8 carry-out case: 100+200 = 300.
    cur = 1;
    do_reset();
    step(1, 100, 0,0,0,1,0,0);
    step(1, 200, 1,0,0,2,0,0);
`ifdef FIB_CHECKER_OVF_EN
    step(1, 44,  1,0,0,2,0,1);
    step(1, 5,   1,0,0,2,0,1);
`else
    step(1, 44,  1,0,0,3,0,0);
    step(1, 244, 1,0,0,4,0,0);
`endif

    // 2-bit counters saturate; comparison continues after saturation.
    cur = 2;
    do_reset();
    step(1, 0, 0,0,0,1,0,0);
    step(1, 1, 1,0,0,2,0,0);
    step(1, 1, 1,0,0,3,0,0);
    step(1, 2, 1,0,0,3,0,0);
    step(1, 3, 1,0,0,3,0,0);
    step(1, 5, 1,0,0,3,0,0);
    step(1, 9, 1,1,1,3,3,0);
    step(1, 0, 1,1,2,3,3,0);
    step(1, 1, 1,1,3,3,3,0);
    step(1, 0, 1,1,3,3,3,0);

    @(negedge clk);
    if0.en = 1'b0; if1.en = 1'b0; if2.en = 1'b0;
    budget = 0;
    while (sbq.size() > 0 && budget < 10) begin
      @(posedge clk);
      budget++;
    end
    #2;
    if (sbq.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fib_checker.md
FIB_CHECKER -- requirements
Module: fib_checker

Interface
REQ-001 SHALL have parameter W, default 96: width of the sampled sequence word.
REQ-002 SHALL have parameter CNT_W, default 16: width of all counters and the index output.
REQ-003 SHALL have port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port en, input, 1: sample qualifier; y is sampled on each rising clk edge where en=1.
REQ-006 SHALL have port y, input, W: sequence word from the generator under test.
REQ-007 SHALL have port locked, output, 1: high once two seed samples have been captured.
REQ-008 SHALL have port err, output, 1: sticky high after the first mismatch.
REQ-009 SHALL have port err_cnt, output, CNT_W: number of mismatching samples.
REQ-010 SHALL have port sample_cnt, output, CNT_W: number of samples taken.
REQ-011 SHALL have port first_err_idx, output, CNT_W: 0-based sample index of the first mismatch.
REQ-012 SHALL have port ovf, output, 1: arithmetic-overflow flag, as defined under Configuration.

Function
REQ-013 SHALL implement states IDLE, SEED, CHECK and HALT; only a sampling edge (en=1) causes a transition.
REQ-014 IDLE, sampling edge: a<=y, sample_cnt<=1, go to SEED.
REQ-015 SEED, sampling edge: b<=y, locked<=1, sample_cnt<=2, go to CHECK.
REQ-016 CHECK, sampling edge: expected=(a+b) mod 2^W, computed from registered a and b; compare with y.
REQ-017 CHECK, every sampling edge: a<=b and b<=y regardless of match, so the checker tests each sample against the two previous received values.
REQ-018 On mismatch: err<=1 and err_cnt increments; if err was 0, first_err_idx<=sample index (sample_cnt before increment).
REQ-019 All outputs SHALL be registered and reflect a sample from the clock edge after that sample is taken; there is no combinational path from y or en to any output.
REQ-020 sample_cnt and err_cnt SHALL saturate at 2^CNT_W-1 and not wrap; comparison continues after saturation.
REQ-021 With en=0, all registers and the state SHALL hold; en gaps of any length are transparent to checking.
REQ-022 HALT: no sampling and no counting; HALT is left only by reset.

Reset
REQ-023 rst=0 SHALL immediately force state IDLE, and set a=b=0, locked=0, err=0, err_cnt=0, sample_cnt=0, first_err_idx=0 and ovf=0.
REQ-024 Reset asserted mid-sequence SHALL discard the seeds; after release, the next two samples re-seed.
REQ-025 Reset is released synchronously to clk by the environment; no sampling occurs in the edge during which rst=0.

Configuration
REQ-026 Macro FIB_CHECKER_OVF_EN defined: in CHECK, if the W+1-bit sum a+b has its MSB set, then ovf<=1, the sample is neither compared nor counted, and the state goes to HALT.
REQ-027 Macro FIB_CHECKER_OVF_EN undefined: the sum wraps modulo 2^W, checking continues, and ovf is tied to 0.

Verification
REQ-028 Sequence 0,1,1,2,3,5,8 with en=1 every cycle -> locked=1 after the 2nd sample, err=0, err_cnt=0, sample_cnt=7.
REQ-029 Sequence 0,1,1,3,4,7 -> err=1 one cycle after sample 3, err_cnt=1, first_err_idx=3; samples 4 and 7 are accepted (each is the sum of the prior two received values).
REQ-030 Sequence 0,1,1,2 with en toggled 1,0,0,1,0,1,1 across cycles -> sample_cnt=4, err=0, and the held state is unchanged during en=0.
REQ-031 Sequence 0,1,1,2,9 followed by rst pulse low, then 5,8,13 -> after reset all outputs are 0; final state locked=1, err=0, sample_cnt=3.
REQ-032 W=8, sequence 100,200,44: with FIB_CHECKER_OVF_EN, ovf=1, the state goes to HALT and sample_cnt=2; without the macro, ovf=0, err=0 and sample_cnt=3.
REQ-033 W=8, CNT_W=2, sequence 0,1,1,2,3,5 -> sample_cnt saturates at 3, err=0.
